// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word geometry, schedule FSM encoding and the
// small sigma functions used by the message-schedule expansion.
package sha256_pkg;

    localparam int WORD_W    = 32;
    localparam int NUM_WORDS = 64;
    localparam int BLK_WORDS = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXPAND = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic logic [WORD_W-1:0] small_sigma0(input logic [WORD_W-1:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [WORD_W-1:0] small_sigma1(input logic [WORD_W-1:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage

// File: rtl/schedule_word.sv
// Combinational next-word generator: W[t] from W[t-2], W[t-7], W[t-15], W[t-16].
module schedule_word
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] w_m2,
    input  logic [WORD_W-1:0] w_m7,
    input  logic [WORD_W-1:0] w_m15,
    input  logic [WORD_W-1:0] w_m16,
    output logic [WORD_W-1:0] w_t
);

    // Additions wrap at 2^32; the carry out is intentionally discarded.
    assign w_t = small_sigma1(w_m2) + w_m7 + small_sigma0(w_m15) + w_m16;

endmodule

// File: rtl/message_schedule.sv
// SHA-256 message-schedule expander: loads a 512-bit block and produces
// W[0..63] one word per clock from a sliding 16-word window.
module message_schedule
    import sha256_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [511:0]  block_in,
    output logic          busy,
    output logic          done,
    output logic          schedule_valid,
    output logic [2047:0] schedule_out
);

    // Handshake: start is taken only when busy=0 (IDLE); it is never queued.
    // block_in is sampled on that edge alone. schedule_out may be consumed
    // while schedule_valid=1, which holds until the cycle after the next start.

    state_t            state, state_next;
    logic [WORD_W-1:0] window [BLK_WORDS];
    logic [WORD_W-1:0] sched  [NUM_WORDS];
    logic [5:0]        idx;
    logic [WORD_W-1:0] w_new;
    logic              accept;
    logic              last;

    assign accept = (state == ST_IDLE) && start;
    assign last   = (state == ST_EXPAND) && (idx == 6'd63);
    assign busy   = (state != ST_IDLE);

    // window[15] is W[t-1], so W[t-k] sits at window[16-k].
    schedule_word u_word (
        .w_m2  (window[14]),
        .w_m7  (window[9]),
        .w_m15 (window[1]),
        .w_m16 (window[0]),
        .w_t   (w_new)
    );

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_EXPAND;
            ST_EXPAND: if (idx == 6'd63) state_next = ST_DONE;
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx            <= '0;
            done           <= 1'b0;
            schedule_valid <= 1'b0;
            for (int i = 0; i < BLK_WORDS; i++) window[i] <= '0;
            for (int i = 0; i < NUM_WORDS; i++) sched[i]  <= '0;
        end else begin
            done <= last;
            if (accept) begin
                for (int i = 0; i < BLK_WORDS; i++) begin
                    window[i] <= block_in[511-32*i -: 32];
                    sched[i]  <= block_in[511-32*i -: 32];
                end
                idx            <= 6'd16;
                schedule_valid <= 1'b0;
            end else if (state == ST_EXPAND) begin
                for (int i = 0; i < BLK_WORDS-1; i++) window[i] <= window[i+1];
                window[BLK_WORDS-1] <= w_new;
                sched[idx]          <= w_new;
                idx                 <= idx + 6'd1;
                if (idx == 6'd63) schedule_valid <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NUM_WORDS; g++) begin : g_pack
        assign schedule_out[NUM_WORDS*WORD_W-1-WORD_W*g -: WORD_W] = sched[g];
    end

endmodule

// File: tb/tb_message_schedule.sv
// Self-checking bench for message_schedule: reference schedule model,
// expected-schedule queue and an independent done-triggered monitor.
module tb_message_schedule;

    logic          clk;
    logic          rst;
    logic          start;
    logic [511:0]  block_in;
    logic          busy;
    logic          done;
    logic          schedule_valid;
    logic [2047:0] schedule_out;

    logic [2047:0] exp_q[$];
    int            n_checks;
    int            n_pass;

    logic [511:0]  abc_blk;
    logic [511:0]  zero_blk;

    message_schedule dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .block_in       (block_in),
        .busy           (busy),
        .done           (done),
        .schedule_valid (schedule_valid),
        .schedule_out   (schedule_out)
    );

    // ---------------- clock / watchdog ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [2047:0] ref_schedule(input logic [511:0] blk);
        logic [31:0]   w [64];
        logic [2047:0] r;
        logic [31:0]   s0, s1;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int t = 16; t < 64; t++) begin
            s0   = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1   = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        r = '0;
        for (int i = 0; i < 64; i++) r[2047-32*i -: 32] = w[i];
        return r;
    endfunction

    function automatic logic [31:0] word_of(input logic [2047:0] s, input int i);
        return s[2047-32*i -: 32];
    endfunction

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom;
        return b;
    endfunction

    task automatic check(input string name, input logic ok,
                         input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (!rst && done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 1'b0, 32'd1, 32'd0);
            end else begin
                logic [2047:0] e;
                int            bad;
                e   = exp_q.pop_front();
                bad = -1;
                for (int i = 0; i < 64; i++)
                    if (bad < 0 && word_of(schedule_out, i) !== word_of(e, i)) bad = i;
                if (bad < 0) check("schedule", 1'b1, 32'd0, 32'd0);
                else begin
                    $display("FAIL schedule: first bad word W%0d", bad);
                    check("schedule_word", 1'b0, word_of(schedule_out, bad), word_of(e, bad));
                end
                check("valid_with_done", schedule_valid === 1'b1, 32'(schedule_valid), 32'd1);
            end
        end
    end

    // ---------------- driver ----------------
    // One accepted run from IDLE. done must first appear after edge 48
    // (the 49th cycle after acceptance). pulse_ignored re-asserts start at
    // edges 5 and 48; abort_at>0 applies reset after that edge instead.
    task automatic run_block(input logic [511:0] blk, input bit pulse_ignored,
                             input int abort_at);
        int done_edge;
        @(negedge clk);
        block_in = blk;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        exp_q.push_back(ref_schedule(blk));
        block_in = rand_block();
        check("busy_after_accept", busy === 1'b1, 32'(busy), 32'd1);
        check("valid_low_after_accept", schedule_valid === 1'b0, 32'(schedule_valid), 32'd0);
        done_edge = -1;
        for (int c = 1; c <= 60; c++) begin
            if (pulse_ignored && (c == 5 || c == 48)) begin
                start    = 1'b1;
                block_in = rand_block();
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (c == abort_at) begin
                rst = 1'b1;
                exp_q.delete();
                @(posedge clk);
                #1;
                check("rst_busy", busy === 1'b0, 32'(busy), 32'd0);
                check("rst_valid", schedule_valid === 1'b0, 32'(schedule_valid), 32'd0);
                check("rst_done", done === 1'b0, 32'(done), 32'd0);
                check("rst_out_zero", schedule_out === '0, 32'(|schedule_out), 32'd0);
                rst = 1'b0;
                return;
            end
            if (done === 1'b1 && done_edge < 0) done_edge = c;
            if (done_edge >= 0 && c == done_edge + 1) break;
        end
        check("done_latency", done_edge == 48, 32'(done_edge), 32'd48);
        check("idle_busy", busy === 1'b0, 32'(busy), 32'd0);
        check("done_one_cycle", done === 1'b0, 32'(done), 32'd0);
        check("valid_held", schedule_valid === 1'b1, 32'(schedule_valid), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        block_in = '0;
        zero_blk = '0;
        abc_blk  = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[31:0]    = 32'h00000018;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy === 1'b0, 32'(busy), 32'd0);
        check("reset_done", done === 1'b0, 32'(done), 32'd0);
        check("reset_valid", schedule_valid === 1'b0, 32'(schedule_valid), 32'd0);
        check("reset_out", schedule_out === '0, 32'(|schedule_out), 32'd0);
        rst = 1'b0;

        // "abc" block with known-answer words
        run_block(abc_blk, 1'b0, 0);
        check("abc_w16", word_of(schedule_out, 16) === 32'h61626380, word_of(schedule_out, 16), 32'h61626380);
        check("abc_w17", word_of(schedule_out, 17) === 32'h000F0000, word_of(schedule_out, 17), 32'h000F0000);
        check("abc_w18", word_of(schedule_out, 18) === 32'h7DA86405, word_of(schedule_out, 18), 32'h7DA86405);
        check("abc_w19", word_of(schedule_out, 19) === 32'h600003C6, word_of(schedule_out, 19), 32'h600003C6);
        check("abc_w63", word_of(schedule_out, 63) === 32'h12B1EDEB, word_of(schedule_out, 63), 32'h12B1EDEB);

        // all-zero block; valid must stay up with no further done pulses
        run_block(zero_blk, 1'b0, 0);
        repeat (5) begin
            @(posedge clk);
            #1;
            check("zero_valid_hold", schedule_valid === 1'b1, 32'(schedule_valid), 32'd1);
            check("zero_no_redone", done === 1'b0, 32'(done), 32'd0);
            check("zero_out", schedule_out === '0, 32'(|schedule_out), 32'd0);
        end

        // start re-pulsed while busy with a different block must be ignored
        run_block(abc_blk, 1'b1, 0);
        check("ignored_w63", word_of(schedule_out, 63) === 32'h12B1EDEB, word_of(schedule_out, 63), 32'h12B1EDEB);

        // reset mid-expansion, then a fresh run
        run_block(rand_block(), 1'b0, 20);
        run_block(abc_blk, 1'b0, 0);
        check("post_rst_w63", word_of(schedule_out, 63) === 32'h12B1EDEB, word_of(schedule_out, 63), 32'h12B1EDEB);

        // start held high: acceptances at relative edges 0, 50, 100
        @(negedge clk);
        block_in = abc_blk;
        start    = 1'b1;
        exp_q.push_back(ref_schedule(abc_blk));
        exp_q.push_back(ref_schedule(zero_blk));
        exp_q.push_back(ref_schedule(abc_blk));
        for (int e = 0; e <= 150; e++) begin
            @(posedge clk);
            #1;
            if (e == 0)   block_in = zero_blk;
            if (e == 50)  block_in = abc_blk;
            if (e == 100) start = 1'b0;
            if (e >= 1) begin
                check("held_done", done === (e == 48 || e == 98 || e == 148),
                      32'(done), 32'(e == 48 || e == 98 || e == 148));
                check("held_busy", busy === !(e == 49 || e == 99 || e >= 149),
                      32'(busy), 32'(!(e == 49 || e == 99 || e >= 149)));
            end
        end

        // randomized blocks against the reference model
        for (int r = 0; r < 200; r++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            run_block(rand_block(), 1'b0, 0);
        end

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size() == 0, 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
